// File: rtl/gmac_csr_pkg.sv
// Shared constants and FSM encoding for the GMAC CSR bus arbiter.
package gmac_csr_pkg;

    localparam int unsigned CSR_AW = 8;
    localparam int unsigned CSR_DW = 32;

    localparam logic [CSR_DW-1:0] TO_FILL_DEFAULT = 32'hDEADBEEF;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } csr_state_e;

endpackage

// File: rtl/gmac_csr_arbiter_rr_pick.sv
// Combinational round-robin picker: first pending index after last_i, wrapping modulo NReq.
module gmac_csr_arbiter_rr_pick #(
    parameter int unsigned NReq = 3,
    parameter int unsigned IdxW = 2
) (
    input  logic [NReq-1:0] req_i,
    input  logic [IdxW-1:0] last_i,
    output logic            valid_o,
    output logic [NReq-1:0] onehot_o,
    output logic [IdxW-1:0] idx_o
);

    int unsigned k;

    always_comb begin
        valid_o  = 1'b0;
        onehot_o = '0;
        idx_o    = '0;
        k        = 0;
        for (int unsigned i = 1; i <= NReq; i++) begin
            k = (32'(last_i) + i) % NReq;
            if (!valid_o && req_i[k]) begin
                valid_o     = 1'b1;
                onehot_o[k] = 1'b1;
                idx_o       = IdxW'(k);
            end
        end
    end

endmodule

// File: rtl/gmac_csr_arbiter.sv
// Round-robin arbiter sharing one GMAC CSR bus between N_REQ requesters, with a per-transfer
// watchdog that forces completion when the slave holds waitrequest too long.
module gmac_csr_arbiter
    import gmac_csr_pkg::*;
#(
    parameter int unsigned        N_REQ       = 3,
    parameter int unsigned        TIMEOUT_CYC = 1024,
    parameter logic [CSR_DW-1:0]  TO_FILL     = TO_FILL_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ*CSR_AW-1:0]  i_req_addr,
    input  logic [N_REQ*CSR_DW-1:0]  i_req_wr_data,
    input  logic [N_REQ-1:0]         i_req_wr,
    input  logic [N_REQ-1:0]         i_req_rd,
    output logic [CSR_DW-1:0]        o_req_rd_data,
    output logic [N_REQ-1:0]         o_req_wtrq,
    output logic [CSR_AW-1:0]        o_addr,
    output logic [CSR_DW-1:0]        o_wr_data,
    output logic                     o_wr,
    output logic                     o_rd,
    input  logic [CSR_DW-1:0]        i_rd_data,
    input  logic                     i_wtrq,
    output logic [N_REQ-1:0]         o_grant,
    output logic                     o_timeout,
    input  logic                     i_timeout_clr
);

    localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CntW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CntW-1:0] CntExpire = (TIMEOUT_CYC == 0) ? '0 : CntW'(TIMEOUT_CYC - 1);

    csr_state_e       state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IdxW-1:0]  last_q, last_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    logic             pick_valid;
    logic [N_REQ-1:0] pick_onehot;
    logic [IdxW-1:0]  pick_idx;

    logic             g_wr, g_rd, expire;

    gmac_csr_arbiter_rr_pick #(
        .NReq (N_REQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i    (i_req_rd | i_req_wr),
        .last_i   (last_q),
        .valid_o  (pick_valid),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx)
    );

    // last_q doubles as the granted index while BUSY.
    assign g_wr   = i_req_wr[last_q];
    assign g_rd   = i_req_rd[last_q];
    assign expire = (TIMEOUT_CYC != 0) && i_wtrq && (cnt_q == CntExpire);

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        timeout_d     = timeout_q;
        o_addr        = '0;
        o_wr_data     = '0;
        o_wr          = 1'b0;
        o_rd          = 1'b0;
        o_req_wtrq    = '1;
        o_req_rd_data = '0;

        if (i_timeout_clr) begin
            timeout_d = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    grant_d = pick_onehot;
                    last_d  = pick_idx;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (!(g_wr || g_rd)) begin
                    grant_d = '0;
                    state_d = StIdle;
                end else if (expire) begin
                    o_req_wtrq[last_q] = 1'b0;
                    o_req_rd_data      = TO_FILL;
                    timeout_d          = 1'b1;
                    grant_d            = '0;
                    state_d            = StIdle;
                end else begin
                    o_addr    = i_req_addr[last_q*CSR_AW +: CSR_AW];
                    o_wr_data = i_req_wr_data[last_q*CSR_DW +: CSR_DW];
                    o_wr      = g_wr;
                    o_rd      = !g_wr && g_rd;
                    if (!i_wtrq) begin
                        o_req_wtrq[last_q] = 1'b0;
                        o_req_rd_data      = i_rd_data;
                        grant_d            = '0;
                        state_d            = StIdle;
                    end else if (cnt_q != '1) begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    assign o_grant   = grant_q;
    assign o_timeout = timeout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            last_q    <= IdxW'(N_REQ - 1);
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_gmac_csr_arbiter.sv
// Directed bench for gmac_csr_arbiter: inputs change 1ns after posedge, outputs sampled at negedge.
module tb_gmac_csr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [23:0] i_req_addr;
    logic [95:0] i_req_wr_data;
    logic [2:0]  i_req_wr;
    logic [2:0]  i_req_rd;
    logic [31:0] o_req_rd_data;
    logic [2:0]  o_req_wtrq;
    logic [7:0]  o_addr;
    logic [31:0] o_wr_data;
    logic        o_wr;
    logic        o_rd;
    logic [31:0] i_rd_data;
    logic        i_wtrq;
    logic [2:0]  o_grant;
    logic        o_timeout;
    logic        i_timeout_clr;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gmac_csr_arbiter #(
        .N_REQ       (3),
        .TIMEOUT_CYC (16),
        .TO_FILL     (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req_addr    (i_req_addr),
        .i_req_wr_data (i_req_wr_data),
        .i_req_wr      (i_req_wr),
        .i_req_rd      (i_req_rd),
        .o_req_rd_data (o_req_rd_data),
        .o_req_wtrq    (o_req_wtrq),
        .o_addr        (o_addr),
        .o_wr_data     (o_wr_data),
        .o_wr          (o_wr),
        .o_rd          (o_rd),
        .i_rd_data     (i_rd_data),
        .i_wtrq        (i_wtrq),
        .o_grant       (o_grant),
        .o_timeout     (o_timeout),
        .i_timeout_clr (i_timeout_clr)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Expected grants for all three ports reading continuously with a zero-wait slave.
    logic [2:0] rot_exp [10] = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100,
                                 3'b000, 3'b001, 3'b000, 3'b010, 3'b000};

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst_n         = 1'b0;
        i_req_addr    = {8'h33, 8'h22, 8'h02};
        i_req_wr_data = {32'h8000, 32'h1111, 32'h0};
        i_req_wr      = 3'b000;
        i_req_rd      = 3'b000;
        i_rd_data     = 32'h0;
        i_wtrq        = 1'b0;
        i_timeout_clr = 1'b0;

        // Reset state
        smp();
        check_eq("rst_grant", 32'(o_grant), 32'h0);
        check_eq("rst_wtrq", 32'(o_req_wtrq), 32'h7);
        check_eq("rst_rdwr", 32'({o_rd, o_wr}), 32'h0);
        check_eq("rst_addr", 32'(o_addr), 32'h0);
        check_eq("rst_timeout", 32'(o_timeout), 32'h0);
        nx();
        rst_n = 1'b1;
        nx();

        // Single read from port 0, slave waits 3 cycles
        i_req_rd = 3'b001;
        i_wtrq   = 1'b1;
        smp();
        check_eq("rd_idle_rd", 32'(o_rd), 32'h0);
        nx();
        smp();
        check_eq("rd_grant", 32'(o_grant), 32'h1);
        check_eq("rd_strobe", 32'(o_rd), 32'h1);
        check_eq("rd_addr", 32'(o_addr), 32'h02);
        check_eq("rd_wait_wtrq", 32'(o_req_wtrq), 32'h7);
        nx();
        nx();
        smp();
        check_eq("rd_wait3_wtrq", 32'(o_req_wtrq), 32'h7);
        nx();
        i_wtrq    = 1'b0;
        i_rd_data = 32'h8;
        smp();
        check_eq("rd_done_wtrq", 32'(o_req_wtrq), 32'h6);
        check_eq("rd_done_data", o_req_rd_data, 32'h8);
        nx();
        i_req_rd = 3'b000;
        smp();
        check_eq("rd_after_grant", 32'(o_grant), 32'h0);
        check_eq("rd_after_data", o_req_rd_data, 32'h0);
        check_eq("rd_after_wtrq", 32'(o_req_wtrq), 32'h7);
        nx();

        // Port 2 asserts rd and wr together: write wins
        i_req_addr = {8'h80, 8'h22, 8'h02};
        i_req_rd   = 3'b100;
        i_req_wr   = 3'b100;
        nx();
        smp();
        check_eq("conf_grant", 32'(o_grant), 32'h4);
        check_eq("conf_wr", 32'(o_wr), 32'h1);
        check_eq("conf_rd", 32'(o_rd), 32'h0);
        check_eq("conf_wdata", o_wr_data, 32'h8000);
        check_eq("conf_addr", 32'(o_addr), 32'h80);
        check_eq("conf_wtrq", 32'(o_req_wtrq), 32'h3);
        nx();
        i_req_rd = 3'b000;
        i_req_wr = 3'b000;
        nx();

        // Watchdog: port 1 writes, slave stuck in waitrequest
        i_req_wr = 3'b010;
        i_wtrq   = 1'b1;
        nx();
        smp();
        check_eq("wd_grant", 32'(o_grant), 32'h2);
        check_eq("wd_wr", 32'(o_wr), 32'h1);
        check_eq("wd_wdata", o_wr_data, 32'h1111);
        for (int b = 2; b <= 15; b++) nx();
        smp();
        check_eq("wd_c15_wtrq", 32'(o_req_wtrq), 32'h7);
        check_eq("wd_c15_to", 32'(o_timeout), 32'h0);
        nx();
        smp();
        check_eq("wd_c16_wtrq", 32'(o_req_wtrq), 32'h5);
        check_eq("wd_c16_wr", 32'(o_wr), 32'h0);
        check_eq("wd_c16_fill", o_req_rd_data, 32'hDEADBEEF);
        nx();
        i_req_wr = 3'b000;
        i_wtrq   = 1'b0;
        smp();
        check_eq("wd_to_set", 32'(o_timeout), 32'h1);
        check_eq("wd_idle_grant", 32'(o_grant), 32'h0);
        nx();
        nx();
        smp();
        check_eq("wd_to_sticky", 32'(o_timeout), 32'h1);
        nx();
        i_timeout_clr = 1'b1;
        smp();
        check_eq("wd_to_clr_cyc", 32'(o_timeout), 32'h1);
        nx();
        i_timeout_clr = 1'b0;
        smp();
        check_eq("wd_to_cleared", 32'(o_timeout), 32'h0);
        nx();

        // Abort: port 0 granted, drops rd while slave waits; port 1 pending
        i_req_rd = 3'b011;
        i_wtrq   = 1'b1;
        nx();
        smp();
        check_eq("ab_grant0", 32'(o_grant), 32'h1);
        check_eq("ab_rd", 32'(o_rd), 32'h1);
        nx();
        i_req_rd = 3'b010;
        smp();
        check_eq("ab_drop_rd", 32'(o_rd), 32'h0);
        check_eq("ab_drop_wtrq", 32'(o_req_wtrq), 32'h7);
        nx();
        smp();
        check_eq("ab_idle", 32'(o_grant), 32'h0);
        nx();
        smp();
        check_eq("ab_grant1", 32'(o_grant), 32'h2);
        check_eq("ab_addr1", 32'(o_addr), 32'h22);

        // Reset mid-BUSY during port 1 read
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("rstb_rd", 32'(o_rd), 32'h0);
        check_eq("rstb_wtrq", 32'(o_req_wtrq), 32'h7);
        check_eq("rstb_grant", 32'(o_grant), 32'h0);
        i_req_rd  = 3'b111;
        i_wtrq    = 1'b0;
        i_rd_data = 32'h55;
        nx();
        rst_n = 1'b1;
        smp();
        check_eq("rstb_idle", 32'(o_grant), 32'h0);

        // Rotation with all ports reading continuously
        for (int i = 0; i < 10; i++) begin
            nx();
            smp();
            check_eq($sformatf("rot_grant_%0d", i), 32'(o_grant), 32'(rot_exp[i]));
            check_eq($sformatf("rot_wtrq_%0d", i), 32'(o_req_wtrq), 32'(3'b111 ^ rot_exp[i]));
            check_eq($sformatf("rot_data_%0d", i), o_req_rd_data,
                     (rot_exp[i] != 3'b000) ? 32'h55 : 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
